ysyx_24090003_ifu: RTL and testbench
====================================

# ysyx_24090003_ifu

Instruction fetch unit. Holds the architectural PC, issues single-beat reads to instruction memory over an AXI4-Lite-style read channel, and presents the fetched word to the decode unit with a valid/ready handshake. It is the producer of the `inst` word that decode splits into fields. The next PC is returned from the execute/writeback stage before the following fetch starts, so the unit is strictly one instruction in flight (multi-cycle, non-pipelined core).

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.

Ports:
- `cpu_clk`  in  1  core clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `araddr`  out  32  read address, always word-aligned.
- `arvalid`  out  1  read address valid.
- `arready`  in  1  memory accepts address.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response, 2'b00 = OKAY.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  IFU accepts read data.
- `inst`  out  32  fetched instruction to decode.
- `pc`  out  32  address of `inst`.
- `inst_valid`  out  1  `inst`/`pc` valid.
- `inst_ready`  in  1  decode accepts instruction.
- `npc`  in  32  next PC from execute/writeback.
- `npc_valid`  in  1  `npc` valid, single-cycle pulse.
- `fault`  out  1  sticky fetch fault.

## Operation
- States: IDLE, AR, R, OUT, WAIT_PC, FAULT. Reset state IDLE.
- Moore outputs: `arvalid`=(AR), `rready`=(R), `inst_valid`=(OUT); `araddr` = `pc`.
- IDLE -> AR unconditionally.
- AR: hold `arvalid`=1, `araddr` stable until `arready`; on `arvalid&&arready` -> R.
- R: on `rvalid&&rready`: latch `rdata` into `inst`, -> OUT (or FAULT, see Configuration).
- OUT: hold `inst`, `pc`, `inst_valid` until `inst_ready`.
  - `inst_ready && !npc_valid` -> WAIT_PC.
  - `inst_ready && npc_valid` (single-cycle execute) -> latch `npc`, -> AR.
- WAIT_PC: on `npc_valid` latch `npc` -> AR.
- `npc_valid` in IDLE, AR, R, or in OUT without `inst_ready`: ignored, no state or PC change.
- PC latch: `pc <= {npc[31:2], 2'b00}`; low two bits discarded silently.
- FAULT: all handshake outputs 0, `fault`=1; exits only on `rst`.
- `rdata` sampled only on R-state handshake; data outside R is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, `araddr`=`RESET_PC`, `arvalid`=0, `rready`=0, `inst`=0, `inst_valid`=0, `fault`=0.
- `rst` high in any state (including mid-AR with `arvalid`=1 or mid-R) -> IDLE next edge; outstanding transaction abandoned; memory must tolerate the dropped request.
- Cycle 0 = first cycle with `rst` low (IDLE); `arvalid` rises cycle 1.
- Zero-wait memory (`arready`, `rvalid` high on first opportunity): AR cycle 1, R cycle 2, `inst_valid` cycle 3.
- Each wait cycle on `arready`, `rvalid`, `inst_ready` or `npc_valid` adds exactly one cycle.
- Back-to-back with `inst_ready`&&`npc_valid` in the first OUT cycle: next `arvalid` the following cycle; fetch-to-fetch period 3 cycles.
- No combinational paths from any input to any output.

## Configuration
- `YSYX_24090003_IFU_RRESP_CHECK_EN` defined: on R handshake with `rresp != 2'b00` -> FAULT, `inst` not updated, `inst_valid` never asserted for that fetch; `pc` keeps faulting address.
- Undefined: `rresp` ignored, `fault` tied 0, FAULT state unreachable; data always forwarded.

## Test plan
- Reset release, memory always ready, `rdata`=32'h0000_0513 -> `araddr`=32'h8000_0000 with `arvalid` cycle 1, `inst_valid` cycle 3 with `inst`=32'h0000_0513, `pc`=32'h8000_0000.
- `arready` low 4 cycles, `rvalid` low 2 cycles -> `arvalid`/`araddr` held stable throughout, `inst_valid` at cycle 9; no duplicate address handshake.
- `inst_ready` and `npc_valid` (`npc`=32'h8000_0004) same cycle in OUT -> next `araddr`=32'h8000_0004 one cycle later; then `npc`=32'h8000_0013 via WAIT_PC -> `araddr`=32'h8000_0010.
- `npc_valid` pulsed during AR and R -> ignored; `pc` unchanged, FSM waits in WAIT_PC for a later pulse.
- `rst` asserted while `arvalid`=1 at 32'h8000_0020 -> next cycle all outputs at reset values, refetch from 32'h8000_0000.
- With macro: `rresp`=2'b10 on handshake -> `fault`=1 next cycle, `inst_valid` stays 0, no further `arvalid` until `rst`; without macro same stimulus -> `inst` forwarded, `fault`=0.

Source files
------------

// File: rtl/ysyx_24090003_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_24090003_ifu
// Brief    : Instruction fetch unit for a multi-cycle core. It holds the PC,
//            issues one single-beat read per instruction on an AXI4-Lite-style
//            read channel, and hands the fetched word to decode through a
//            valid/ready handshake. Only one instruction is in flight at a
//            time: the next PC comes back from execute/writeback before the
//            following fetch starts.
// Option   : YSYX_24090003_IFU_RRESP_CHECK_EN - when defined, a read response
//            other than OKAY sends the unit into a sticky FAULT state.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_24090003_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        cpu_clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [31:0] npc,
   input  logic        npc_valid,
   output logic        fault
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_AR      = 3'd1;
   localparam logic [2:0] S_R       = 3'd2;
   localparam logic [2:0] S_OUT     = 3'd3;
   localparam logic [2:0] S_WAIT_PC = 3'd4;
   localparam logic [2:0] S_FAULT   = 3'd5;

   logic [2:0]  r_state;
   logic [2:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        w_r_hs;
   logic        w_rresp_err;
   logic        w_pc_load;
   logic        w_unused_bits;

   // A read beat is only accepted while we are the ones asserting rready.
   assign w_r_hs = (r_state == S_R) && rvalid;

`ifdef YSYX_24090003_IFU_RRESP_CHECK_EN
   assign w_rresp_err   = (rresp != 2'b00);
   assign w_unused_bits = ^npc[1:0];
`else
   // Response code is not inspected in this build.
   assign w_rresp_err   = 1'b0;
   assign w_unused_bits = ^{rresp, npc[1:0]};
`endif

   // A new PC is taken either with the accepting handshake in OUT or from
   // the first pulse seen in WAIT_PC; pulses anywhere else are dropped.
   assign w_pc_load = npc_valid &&
                      (((r_state == S_OUT) && inst_ready) || (r_state == S_WAIT_PC));

   // Next-state selection for the fetch sequence.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    w_state_nxt = S_AR;
         S_AR:      if (arready) w_state_nxt = S_R;
         S_R:       if (w_r_hs) w_state_nxt = w_rresp_err ? S_FAULT : S_OUT;
         S_OUT:     if (inst_ready) w_state_nxt = npc_valid ? S_AR : S_WAIT_PC;
         S_WAIT_PC: if (npc_valid) w_state_nxt = S_AR;
         S_FAULT:   w_state_nxt = S_FAULT;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // State, PC and instruction registers; reset abandons any open transaction.
   always_ff @(posedge cpu_clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_inst  <= 32'h0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pc_load) begin
            r_pc <= {npc[31:2], 2'b00};
         end
         if (w_r_hs && !w_rresp_err) begin
            r_inst <= rdata;
         end
      end
   end

   // All outputs decode registered state only.
   assign araddr     = r_pc;
   assign pc         = r_pc;
   assign inst       = r_inst;
   assign arvalid    = (r_state == S_AR);
   assign rready     = (r_state == S_R);
   assign inst_valid = (r_state == S_OUT);
   assign fault      = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090003_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_24090003_ifu
// Brief    : Cycle-table bench for the instruction fetch unit. Each record
//            holds the inputs for one clock cycle and the outputs expected
//            during that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090003_ifu;

   localparam logic [31:0] C_R0  = 32'h8000_0000;
   localparam logic [31:0] C_I1  = 32'h0000_0513;
   localparam logic [31:0] C_I2  = 32'h0010_0093;
   localparam logic [31:0] C_I3  = 32'h00a0_0593;
   localparam logic [31:0] C_I4  = 32'h0000_0013;
   localparam logic [31:0] C_I5  = 32'h1234_5678;

   typedef struct {
      bit          chk;
      logic        rst;
      logic        arready;
      logic        rvalid;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic        inst_ready;
      logic        npc_valid;
      logic [31:0] npc;
      logic        e_arvalid;
      logic        e_rready;
      logic        e_inst_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_fault;
   } vec_t;

   logic        cpu_clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [1:0]  rresp = 2'b00;
   logic        rvalid = 1'b0;
   logic        rready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] npc = 32'h0;
   logic        npc_valid = 1'b0;
   logic        fault;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   ysyx_24090003_ifu #(.RESET_PC(C_R0)) dut (
      .cpu_clk   (cpu_clk),
      .rst       (rst),
      .araddr    (araddr),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rvalid    (rvalid),
      .rready    (rready),
      .inst      (inst),
      .pc        (pc),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .npc       (npc),
      .npc_valid (npc_valid),
      .fault     (fault)
   );

   always #5 cpu_clk = ~cpu_clk;

   function automatic void add(input bit chk, input logic r, input logic ar,
                               input logic rv, input logic [31:0] rd,
                               input logic [1:0] rs, input logic ir,
                               input logic nv, input logic [31:0] np,
                               input logic e_arv, input logic e_rr,
                               input logic e_iv, input logic [31:0] e_pc,
                               input logic [31:0] e_inst, input logic e_f);
      vec_t v;
      v.chk = chk; v.rst = r; v.arready = ar; v.rvalid = rv; v.rdata = rd;
      v.rresp = rs; v.inst_ready = ir; v.npc_valid = nv; v.npc = np;
      v.e_arvalid = e_arv; v.e_rready = e_rr; v.e_inst_valid = e_iv;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_fault = e_f;
      vecs.push_back(v);
   endfunction

   initial begin
      vec_t v;
      vec_t e;
      // ---------------- zero-wait fetch, back-to-back, WAIT_PC ----------------
      //  chk rst ar rv rdata  rs ir nv npc            arv rr iv pc             inst  f
      add(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0);
      add(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0);
      add(1, 0, 1, 1, C_I1,  0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0); // c0 IDLE
      add(1, 0, 1, 1, C_I1,  0, 0, 0, 32'h0,           1, 0, 0, C_R0,          0,    0); // c1 AR
      add(1, 0, 1, 1, C_I1,  0, 0, 0, 32'h0,           0, 1, 0, C_R0,          0,    0); // c2 R
      add(1, 0, 1, 1, C_I2,  0, 1, 1, 32'h8000_0004,   0, 0, 1, C_R0,          C_I1, 0); // c3 OUT
      add(1, 0, 1, 1, C_I2,  0, 0, 0, 32'h0,           1, 0, 0, 32'h8000_0004, C_I1, 0);
      add(1, 0, 1, 1, C_I2,  0, 0, 0, 32'h0,           0, 1, 0, 32'h8000_0004, C_I1, 0);
      add(1, 0, 1, 1, C_I2,  0, 1, 0, 32'h0,           0, 0, 1, 32'h8000_0004, C_I2, 0);
      add(1, 0, 1, 1, C_I2,  0, 0, 0, 32'h0,           0, 0, 0, 32'h8000_0004, C_I2, 0); // WAIT_PC
      add(1, 0, 1, 1, C_I2,  0, 0, 1, 32'h8000_0013,   0, 0, 0, 32'h8000_0004, C_I2, 0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           1, 0, 0, 32'h8000_0010, C_I2, 0);
      // ---------------- stalls, ignored pulses, reset mid-AR ----------------
      add(0, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0);
      add(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0); // c0
      for (int i = 0; i < 4; i++)                                                        // c1..c4
         add(1, 0, 0, 1, 32'hffff_ffff, 0, 0, 0, 32'h0, 1, 0, 0, C_R0,       0,    0);
      add(1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0,           1, 0, 0, C_R0,          0,    0); // c5
      add(1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0,           0, 1, 0, C_R0,          0,    0); // c6
      add(1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0,           0, 1, 0, C_R0,          0,    0); // c7
      add(1, 0, 1, 1, C_I3,  0, 0, 0, 32'h0,           0, 1, 0, C_R0,          0,    0); // c8
      add(1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h8000_0040,   0, 0, 1, C_R0,          C_I3, 0); // c9
      add(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0,           0, 0, 1, C_R0,          C_I3, 0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          C_I3, 0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h8000_0020,   0, 0, 0, C_R0,          C_I3, 0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 1, 32'h8000_0080,   1, 0, 0, 32'h8000_0020, C_I3, 0);
      add(1, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0,           1, 0, 0, 32'h8000_0020, C_I3, 0);
      add(1, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0); // reset values
      add(1, 0, 1, 1, C_I4,  0, 0, 0, 32'h0,           1, 0, 0, C_R0,          0,    0);
      add(1, 0, 1, 1, C_I4,  0, 0, 1, 32'h8000_0100,   0, 1, 0, C_R0,          0,    0);
      add(1, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0,           0, 0, 1, C_R0,          C_I4, 0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          C_I4, 0);
      add(1, 0, 1, 1, C_I5,  0, 0, 1, 32'h8000_0008,   0, 0, 0, C_R0,          C_I4, 0);
      add(1, 0, 1, 1, C_I5,  0, 0, 0, 32'h0,           1, 0, 0, 32'h8000_0008, C_I4, 0);
      // ---------------- error response ----------------
      add(1, 0, 1, 1, C_I5,  2'b10, 0, 0, 32'h0,       0, 1, 0, 32'h8000_0008, C_I4, 0);
`ifdef YSYX_24090003_IFU_RRESP_CHECK_EN
      for (int i = 0; i < 2; i++)
         add(1, 0, 1, 1, C_I5, 0, 1, 1, 32'h8000_0200, 0, 0, 0, 32'h8000_0008, C_I4, 1);
      add(1, 1, 1, 1, C_I5,  0, 0, 0, 32'h0,           0, 0, 0, 32'h8000_0008, C_I4, 1);
`else
      for (int i = 0; i < 2; i++)
         add(1, 0, 1, 1, C_I5, 0, 0, 0, 32'h0,       0, 0, 1, 32'h8000_0008, C_I5, 0);
      add(1, 1, 1, 1, C_I5,  0, 0, 0, 32'h0,           0, 0, 1, 32'h8000_0008, C_I5, 0);
`endif
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           0, 0, 0, C_R0,          0,    0);
      add(1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0,           1, 0, 0, C_R0,          0,    0);

      // Apply: inputs just after a rising edge, outputs sampled on the falling edge.
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         rst = v.rst; arready = v.arready; rvalid = v.rvalid; rdata = v.rdata;
         rresp = v.rresp; inst_ready = v.inst_ready; npc_valid = v.npc_valid;
         npc = v.npc;
         if (v.chk) exp_q.push_back(v);
         @(negedge cpu_clk);
         if (v.chk) begin
            e = exp_q.pop_front();
            total++;
            if (arvalid !== e.e_arvalid || rready !== e.e_rready ||
                inst_valid !== e.e_inst_valid || fault !== e.e_fault ||
                araddr !== e.e_pc || pc !== e.e_pc || inst !== e.e_inst) begin
               bad++;
               $display("FAIL vec%0d: got arv=%b rr=%b iv=%b f=%b araddr=%h pc=%h inst=%h want arv=%b rr=%b iv=%b f=%b pc=%h inst=%h",
                        i, arvalid, rready, inst_valid, fault, araddr, pc, inst,
                        e.e_arvalid, e.e_rready, e.e_inst_valid, e.e_fault, e.e_pc, e.e_inst);
            end
         end
         @(posedge cpu_clk);
         #1;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: left=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
